// File: rtl/fp32_adder_driver_if.sv
// Handshake bundle between the fp32 adder driver, its vector source,
// the adder under test and the result consumer.
interface fp32_adder_driver_if #(
  parameter int CNT_W = 16
);
  // vector source side
  logic             vec_valid_i;
  logic             vec_ready_o;
  logic [31:0]      vec_a_i;
  logic [31:0]      vec_b_i;
  logic [31:0]      vec_exp_i;
  // adder side
  logic             add_ready_i;
  logic             add_valid_stb_o;
  logic [31:0]      add_a_o;
  logic [31:0]      add_b_o;
  logic             add_valid_stb_i;
  logic [31:0]      add_z_i;
  logic             add_ack_z_o;
  // result / status side
  logic             res_valid_o;
  logic [31:0]      res_z_o;
  logic             res_pass_o;
  logic [CNT_W-1:0] pass_cnt_o;
  logic [CNT_W-1:0] fail_cnt_o;
  logic             timeout_o;

  // driver view
  modport master (
    input  vec_valid_i, vec_a_i, vec_b_i, vec_exp_i,
    input  add_ready_i, add_valid_stb_i, add_z_i,
    output vec_ready_o, add_valid_stb_o, add_a_o, add_b_o, add_ack_z_o,
    output res_valid_o, res_z_o, res_pass_o, pass_cnt_o, fail_cnt_o, timeout_o
  );

  // environment view (vector source, adder, result consumer)
  modport slave (
    output vec_valid_i, vec_a_i, vec_b_i, vec_exp_i,
    output add_ready_i, add_valid_stb_i, add_z_i,
    input  vec_ready_o, add_valid_stb_o, add_a_o, add_b_o, add_ack_z_o,
    input  res_valid_o, res_z_o, res_pass_o, pass_cnt_o, fail_cnt_o, timeout_o
  );
endinterface

// File: rtl/fp32_adder_driver.sv
// On-chip fp32 adder regression driver: accepts {a, b, expected} vectors,
// runs the adder strobe/ack handshake, compares z and keeps saturating
// pass/fail counts. A stuck adder is reported once and the driver halts.
module fp32_adder_driver #(
  parameter int ACK_CYCLES = 2,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16,
  parameter bit NAN_ANY    = 1'b1
) (
  input  logic                clk,
  input  logic                arst_n,
  fp32_adder_driver_if.master bus
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int ACK_W = 4;

  typedef enum logic [2:0] {
    IDLE, WAIT_READY, ISSUE, WAIT_RESULT, ACK, REPORT, HALT
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Reset: asserts asynchronously, releases two clocks later in clk domain.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  // reset synchronizer
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) rst_sync_q <= 2'b00;
    else         rst_sync_q <= rst_sync_d;
  end

  state_e           state_q, state_d;
  vec_t             vec_q, vec_d;
  logic [31:0]      z_q, z_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [ACK_W-1:0] ack_q, ack_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_z_q, res_z_d;
  logic             res_pass_q, res_pass_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             timeout_q, timeout_d;
  logic             cmp_pass;
  logic             abort;

  // z vs expected: exact bits, or NaN-to-NaN when allowed
  always_comb begin
    cmp_pass = (z_q == vec_q.exp);
    if (NAN_ANY && is_nan(z_q) && is_nan(vec_q.exp)) cmp_pass = 1'b1;
  end

  // next state, datapath captures, report and counter updates
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    z_d         = z_q;
    tmr_d       = tmr_q;
    ack_d       = ack_q;
    res_valid_d = 1'b0;
    res_z_d     = res_z_q;
    res_pass_d  = res_pass_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    timeout_d   = timeout_q;
    abort       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.vec_valid_i) begin
          vec_d   = '{a: bus.vec_a_i, b: bus.vec_b_i, exp: bus.vec_exp_i};
          tmr_d   = '0;
          state_d = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (bus.add_ready_i)                     state_d = ISSUE;
        else if (tmr_q == TMR_W'(TIMEOUT - 1))   abort   = 1'b1;
        else                                     tmr_d   = tmr_q + TMR_W'(1);
      end
      ISSUE: begin
        tmr_d   = '0;
        state_d = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (bus.add_valid_stb_i) begin
          z_d     = bus.add_z_i;
          ack_d   = '0;
          state_d = ACK;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ACK: begin
        // result strobe is not looked at here; it may drop at any time
        if (ack_q == ACK_W'(ACK_CYCLES - 1)) begin
          state_d     = REPORT;
          res_valid_d = 1'b1;
          res_z_d     = z_q;
          res_pass_d  = cmp_pass;
          if (cmp_pass) begin
            if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
          end else begin
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
          end
        end else begin
          ack_d = ack_q + ACK_W'(1);
        end
      end
      REPORT:  state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    // A late result must never be credited to a later vector, so a stuck
    // adder ends the run: one failing report, then HALT until reset.
    if (abort) begin
      timeout_d   = 1'b1;
      res_valid_d = 1'b1;
      res_z_d     = '0;
      res_pass_d  = 1'b0;
      if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
      state_d     = HALT;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      z_q         <= '0;
      tmr_q       <= '0;
      ack_q       <= '0;
      res_valid_q <= 1'b0;
      res_z_q     <= '0;
      res_pass_q  <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      z_q         <= z_d;
      tmr_q       <= tmr_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
      res_z_q     <= res_z_d;
      res_pass_q  <= res_pass_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Handshake outputs decode straight from state so reset drops them
  // without waiting for a clock edge.
  assign bus.vec_ready_o     = (state_q == IDLE) && rst_n;
  assign bus.add_valid_stb_o = (state_q == ISSUE);
  assign bus.add_ack_z_o     = (state_q == ACK);
  assign bus.add_a_o         = vec_q.a;
  assign bus.add_b_o         = vec_q.b;
  assign bus.res_valid_o     = res_valid_q;
  assign bus.res_z_o         = res_z_q;
  assign bus.res_pass_o      = res_pass_q;
  assign bus.pass_cnt_o      = pass_cnt_q;
  assign bus.fail_cnt_o      = fail_cnt_q;
  assign bus.timeout_o       = timeout_q;

endmodule

// File: tb/tb_fp32_adder_driver.sv
// Directed bench for fp32_adder_driver. Instance A: NAN_ANY=1, CNT_W=16;
// instance B: NAN_ANY=0, CNT_W=2. Both TIMEOUT=8, ACK_CYCLES=2, driven by a
// 5-cycle adder model that returns a preset z.
module tb_fp32_adder_driver;

  localparam int LAT = 5;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic arst_a_n, arst_b_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  fp32_adder_driver_if #(.CNT_W(16)) ifa ();
  fp32_adder_driver_if #(.CNT_W(2))  ifb ();

  fp32_adder_driver #(.ACK_CYCLES(2), .TIMEOUT(8), .CNT_W(16), .NAN_ANY(1'b1)) u_dut_a (
    .clk(clk), .arst_n(arst_a_n), .bus(ifa.master));
  fp32_adder_driver #(.ACK_CYCLES(2), .TIMEOUT(8), .CNT_W(2), .NAN_ANY(1'b0)) u_dut_b (
    .clk(clk), .arst_n(arst_b_n), .bus(ifb.master));

  // observation views indexed by instance select
  wire [1:0]   w_vrdy = {ifb.vec_ready_o,     ifa.vec_ready_o};
  wire [1:0]   w_stb  = {ifb.add_valid_stb_o, ifa.add_valid_stb_o};
  wire [1:0]   w_ack  = {ifb.add_ack_z_o,     ifa.add_ack_z_o};
  wire [1:0]   w_rv   = {ifb.res_valid_o,     ifa.res_valid_o};
  wire [1:0]   w_rp   = {ifb.res_pass_o,      ifa.res_pass_o};
  wire [1:0]   w_to   = {ifb.timeout_o,       ifa.timeout_o};
  logic [31:0] w_rz [2];
  logic [15:0] w_pc [2];
  logic [15:0] w_fc [2];
  assign w_rz[0] = ifa.res_z_o;
  assign w_rz[1] = ifb.res_z_o;
  assign w_pc[0] = ifa.pass_cnt_o;
  assign w_pc[1] = {14'd0, ifb.pass_cnt_o};
  assign w_fc[0] = ifa.fail_cnt_o;
  assign w_fc[1] = {14'd0, ifb.fail_cnt_o};

  // adder models: see strobe, return z LAT cycles later for one cycle
  bit          rdy_en [2];
  logic [31:0] mz     [2];
  int          cnt_a = -1;
  int          cnt_b = -1;

  always @(negedge clk) begin
    ifa.add_valid_stb_i = 1'b0;
    ifa.add_ready_i     = rdy_en[0];
    if (!arst_a_n) begin
      cnt_a = -1;
      ifa.add_z_i = 32'h0;
    end else begin
      if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) begin
          ifa.add_valid_stb_i = 1'b1;
          ifa.add_z_i = mz[0];
          cnt_a = -1;
        end
      end
      if (ifa.add_valid_stb_o) cnt_a = LAT;
    end
  end

  always @(negedge clk) begin
    ifb.add_valid_stb_i = 1'b0;
    ifb.add_ready_i     = rdy_en[1];
    if (!arst_b_n) begin
      cnt_b = -1;
      ifb.add_z_i = 32'h0;
    end else begin
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) begin
          ifb.add_valid_stb_i = 1'b1;
          ifb.add_z_i = mz[1];
          cnt_b = -1;
        end
      end
      if (ifb.add_valid_stb_o) cnt_b = LAT;
    end
  end

  task automatic set_vec(input bit s, input logic v, input logic [31:0] a, b, e);
    if (s) begin
      ifb.vec_valid_i = v; ifb.vec_a_i = a; ifb.vec_b_i = b; ifb.vec_exp_i = e;
    end else begin
      ifa.vec_valid_i = v; ifa.vec_a_i = a; ifa.vec_b_i = b; ifa.vec_exp_i = e;
    end
  endtask

  task automatic wait_ready(input bit s);
    int w = 0;
    while (!w_vrdy[s] && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (!w_vrdy[s]) begin
      n_bad++;
      $display("FAIL ready_wait[%0d]: vec_ready_o=%b want 1", s, w_vrdy[s]);
    end
  endtask

  // Present one vector once the driver is ready; cyc counts negedges from
  // presentation to the first one that sees res_valid_o.
  task automatic run_vec(input bit s, input logic [31:0] a, b, e, z,
                         output logic [31:0] rz, output logic rp,
                         output int cyc, output int nstb, output int nack, output int nrdy);
    wait_ready(s);
    mz[s] = z;
    set_vec(s, 1'b1, a, b, e);
    cyc = 0; nstb = 0; nack = 0; nrdy = 0;
    do begin
      @(negedge clk);
      if (cyc == 0) set_vec(s, 1'b0, a, b, e);
      cyc++;
      nstb += int'(w_stb[s]);
      nack += int'(w_ack[s]);
      nrdy += int'(w_vrdy[s]);
    end while (!w_rv[s] && cyc < 100);
    rz = w_rz[s];
    rp = w_rp[s];
  endtask

  logic [31:0] rz;
  logic        rp;
  int          cyc, nstb, nack, nrdy;

  task automatic test_reset();
    arst_a_n = 1'b0; arst_b_n = 1'b0;
    rdy_en[0] = 1'b1; rdy_en[1] = 1'b1;
    set_vec(0, 1'b0, 32'h0, 32'h0, 32'h0);
    set_vec(1, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    n_cmp++;
    if ({w_vrdy, w_stb, w_ack, w_rv, w_to} !== 10'b0) begin
      n_bad++; $display("FAIL reset_outs: got %b want 0", {w_vrdy, w_stb, w_ack, w_rv, w_to});
    end
    n_cmp++;
    if ({w_pc[0], w_fc[0], w_pc[1], w_fc[1]} !== 64'h0) begin
      n_bad++; $display("FAIL reset_cnts: got %h want 0", {w_pc[0], w_fc[0], w_pc[1], w_fc[1]});
    end
    @(negedge clk);
    arst_a_n = 1'b1; arst_b_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (w_vrdy !== 2'b11) begin
      n_bad++; $display("FAIL reset_ready: got %b want 11", w_vrdy);
    end
  endtask

  task automatic test_basic();
    run_vec(0, 32'h4280DD2F, 32'h4341E666, 32'h43812A7F, 32'h43812A7F, rz, rp, cyc, nstb, nack, nrdy);
    n_cmp++;
    if (rz !== 32'h43812A7F) begin n_bad++; $display("FAIL basic_z: got %h want 43812a7f", rz); end
    n_cmp++;
    if (rp !== 1'b1) begin n_bad++; $display("FAIL basic_pass: got %b want 1", rp); end
    n_cmp++;
    if (nstb !== 1) begin n_bad++; $display("FAIL basic_strobes: got %0d want 1", nstb); end
    n_cmp++;
    if (nack !== 2) begin n_bad++; $display("FAIL basic_ack_cycles: got %0d want 2", nack); end
    n_cmp++;
    if (cyc !== 3 + LAT + 2) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", cyc, 3 + LAT + 2); end
    n_cmp++;
    if (w_pc[0] !== 16'd1 || w_fc[0] !== 16'd0) begin
      n_bad++; $display("FAIL basic_cnts: got %0d/%0d want 1/0", w_pc[0], w_fc[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (w_rv[0] !== 1'b0 || w_rz[0] !== 32'h43812A7F) begin
      n_bad++; $display("FAIL basic_pulse_hold: rv=%b z=%h want 0/43812a7f", w_rv[0], w_rz[0]);
    end
  endtask

  task automatic test_nan();
    run_vec(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FC00000, 32'hFFC00000, rz, rp, cyc, nstb, nack, nrdy);
    n_cmp++;
    if (rp !== 1'b1 || w_pc[0] !== 16'd2) begin
      n_bad++; $display("FAIL nan_any_pass: got %b cnt %0d want 1 cnt 2", rp, w_pc[0]);
    end
    run_vec(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FC00000, 32'hFFC00000, rz, rp, cyc, nstb, nack, nrdy);
    n_cmp++;
    if (rp !== 1'b0 || rz !== 32'hFFC00000) begin
      n_bad++; $display("FAIL nan_exact_fail: got %b z %h want 0 z ffc00000", rp, rz);
    end
    n_cmp++;
    if (w_fc[1] !== 16'd1 || w_pc[1] !== 16'd0) begin
      n_bad++; $display("FAIL nan_exact_cnts: got %0d/%0d want 0/1", w_pc[1], w_fc[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rz1;
    logic        rp1;
    int          nrdy1;
    run_vec(0, 32'h0, 32'h0, 32'h0, 32'h0, rz1, rp1, cyc, nstb, nack, nrdy1);
    run_vec(0, 32'h42BE0F0F, 32'h4385D574, 32'h43B55938, 32'h43B55938, rz, rp, cyc, nstb, nack, nrdy);
    n_cmp++;
    if (nrdy1 !== 0) begin n_bad++; $display("FAIL b2b_ready_low: got %0d ready cycles want 0", nrdy1); end
    n_cmp++;
    if (rz1 !== 32'h0 || rp1 !== 1'b1) begin n_bad++; $display("FAIL b2b_first: got %h/%b want 0/1", rz1, rp1); end
    n_cmp++;
    if (rz !== 32'h43B55938 || rp !== 1'b1) begin n_bad++; $display("FAIL b2b_second: got %h/%b want 43b55938/1", rz, rp); end
    n_cmp++;
    if (w_pc[0] !== 16'd4) begin n_bad++; $display("FAIL b2b_pass_cnt: got %0d want 4", w_pc[0]); end
  endtask

  task automatic test_mismatch();
    run_vec(0, 32'h0, 32'h0, 32'h00000001, 32'h0, rz, rp, cyc, nstb, nack, nrdy);
    n_cmp++;
    if (rp !== 1'b0 || w_fc[0] !== 16'd1) begin
      n_bad++; $display("FAIL wrong_exp: got %b fail %0d want 0 fail 1", rp, w_fc[0]);
    end
    // +Inf against a NaN expectation
    run_vec(0, 32'h7F800000, 32'h0, 32'h7FC00000, 32'h7F800000, rz, rp, cyc, nstb, nack, nrdy);
    n_cmp++;
    if (rp !== 1'b0 || w_fc[0] !== 16'd2) begin
      n_bad++; $display("FAIL inf_vs_nan: got %b fail %0d want 0 fail 2", rp, w_fc[0]);
    end
    // -0 against +0
    run_vec(0, 32'h80000000, 32'h80000000, 32'h00000000, 32'h80000000, rz, rp, cyc, nstb, nack, nrdy);
    n_cmp++;
    if (rp !== 1'b0 || w_fc[0] !== 16'd3 || w_pc[0] !== 16'd4) begin
      n_bad++; $display("FAIL signed_zero: got %b cnt %0d/%0d want 0 cnt 4/3", rp, w_pc[0], w_fc[0]);
    end
  endtask

  task automatic test_timeout();
    int lstb = 0;
    int lrdy = 0;
    rdy_en[0] = 1'b0;
    repeat (2) @(negedge clk);
    run_vec(0, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, rz, rp, cyc, nstb, nack, nrdy);
    n_cmp++;
    if (cyc !== 9) begin n_bad++; $display("FAIL to_delay: got %0d want 9", cyc); end
    n_cmp++;
    if (rp !== 1'b0 || rz !== 32'h0 || w_to[0] !== 1'b1) begin
      n_bad++; $display("FAIL to_report: pass %b z %h to %b want 0/0/1", rp, rz, w_to[0]);
    end
    n_cmp++;
    if (w_fc[0] !== 16'd4 || nstb !== 0) begin
      n_bad++; $display("FAIL to_fail_cnt: got %0d strobes %0d want 4/0", w_fc[0], nstb);
    end
    rdy_en[0] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      lstb += int'(w_stb[0]);
      lrdy += int'(w_vrdy[0]);
    end
    n_cmp++;
    if (lstb !== 0 || lrdy !== 0 || w_to[0] !== 1'b1) begin
      n_bad++; $display("FAIL halt: strobes %0d ready %0d to %b want 0/0/1", lstb, lrdy, w_to[0]);
    end
    arst_a_n = 1'b0;
    #1;
    n_cmp++;
    if (w_to[0] !== 1'b0 || w_pc[0] !== 16'd0 || w_fc[0] !== 16'd0) begin
      n_bad++; $display("FAIL to_reset_clear: to %b cnt %0d/%0d want 0 0/0", w_to[0], w_pc[0], w_fc[0]);
    end
    @(negedge clk);
    arst_a_n = 1'b1;
    run_vec(0, 32'h4280DD2F, 32'h4341E666, 32'h43812A7F, 32'h43812A7F, rz, rp, cyc, nstb, nack, nrdy);
    n_cmp++;
    if (rp !== 1'b1 || w_pc[0] !== 16'd1) begin
      n_bad++; $display("FAIL after_reset: got %b cnt %0d want 1 cnt 1", rp, w_pc[0]);
    end
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 5; i++) begin
      int exp_pc = (i > 3) ? 3 : i;
      run_vec(1, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, rz, rp, cyc, nstb, nack, nrdy);
      n_cmp++;
      if (rp !== 1'b1 || w_pc[1] !== exp_pc[15:0]) begin
        n_bad++; $display("FAIL saturate[%0d]: pass %b cnt %0d want 1 cnt %0d", i, rp, w_pc[1], exp_pc);
      end
    end
  endtask

  task automatic test_reset_mid_ack();
    int w = 0;
    int lrv = 0;
    wait_ready(1);
    mz[1] = 32'h0;
    set_vec(1, 1'b1, 32'h0, 32'h0, 32'h0);
    do begin
      @(negedge clk);
      if (w == 0) set_vec(1, 1'b0, 32'h0, 32'h0, 32'h0);
      w++;
    end while (!w_ack[1] && w < 50);
    n_cmp++;
    if (w_ack[1] !== 1'b1) begin n_bad++; $display("FAIL mid_ack_reach: ack %b want 1", w_ack[1]); end
    #2 arst_b_n = 1'b0;
    #1;
    n_cmp++;
    if (w_ack[1] !== 1'b0 || w_stb[1] !== 1'b0 || w_rv[1] !== 1'b0) begin
      n_bad++; $display("FAIL mid_ack_drop: ack %b stb %b rv %b want 0/0/0", w_ack[1], w_stb[1], w_rv[1]);
    end
    repeat (4) begin
      @(negedge clk);
      lrv += int'(w_rv[1]);
    end
    arst_b_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      lrv += int'(w_rv[1]);
    end
    n_cmp++;
    if (lrv !== 0 || w_vrdy[1] !== 1'b1 || w_pc[1] !== 16'd0) begin
      n_bad++; $display("FAIL mid_ack_after: reports %0d ready %b cnt %0d want 0/1/0", lrv, w_vrdy[1], w_pc[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nan();
    test_back_to_back();
    test_mismatch();
    test_timeout();
    test_saturate();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
